instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_buffer.sv | 74 +++++++
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// buffer entry layout, reset instruction word and PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int          ENTRY_W     = $bits(fetch_entry_t);
    localparam logic [31:0] RESET_INSTR = 32'h0;
    localparam logic [63:0] PC_INCR     = 64'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush empties it
// in one cycle and push/pop in the same cycle keep the occupancy unchanged.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign pop_ok  = pop && (count_q != '0) && !flush;
    assign push_ok = push && !flush && ((count_q < CNT_W'(DEPTH)) || pop_ok);

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an empty count keeps stale
    // entries invisible and the consumer masks the head while invalid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher: one outstanding memory request, a small
// instruction buffer toward the core, and redirect handling that drops stale responses.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        Reset_L,
    output logic        MemReq,
    output logic [63:0] MemAddr,
    input  logic        MemGnt,
    input  logic        MemRespValid,
    input  logic [31:0] MemRespData,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [63:0] InstrPC,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [63:0]      out_pc_q, out_pc_d;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   occ_next;
    logic             mem_req, grant, push, pop, buf_valid, credit_next;
    fetch_entry_t     push_entry, head_entry;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^RedirectPC[1:0];

    // Reset gates the request combinationally so it drops the instant reset asserts.
    assign mem_req   = Reset_L && (state_q == ST_REQ);
    assign grant     = mem_req && MemGnt;
    assign buf_valid = (buf_count != '0);
    assign push      = (state_q == ST_WAIT) && MemRespValid && !Redirect;
    assign pop       = buf_valid && InstrReady && !Redirect;

    always_comb begin
        occ_next    = '0;
        credit_next = 1'b1;
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        out_pc_d    = out_pc_q;

        if (!Redirect) begin
            occ_next = {1'b0, buf_count} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop);
        end
        credit_next = (occ_next < (CNT_W + 1)'(BUF_DEPTH));

        if (grant) begin
            out_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_INCR;
        end

        unique case (state_q)
            ST_REQ:  if (grant) state_d = ST_WAIT;
            ST_WAIT: if (MemRespValid) state_d = credit_next ? ST_REQ : ST_HOLD;
            ST_DROP: if (MemRespValid) state_d = ST_REQ;
            ST_HOLD: if (credit_next) state_d = ST_REQ;
            default: state_d = ST_REQ;
        endcase

        // A request granted or in flight at redirect time belongs to the old
        // stream; DROP swallows its response. A response landing now ends it.
        if (Redirect) begin
            fetch_pc_d = {RedirectPC[63:2], 2'b00};
            unique case (state_q)
                ST_REQ:  state_d = grant ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = MemRespValid ? ST_REQ : ST_DROP;
                ST_DROP: state_d = MemRespValid ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= {RESET_PC[63:2], 2'b00};
            out_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_pc_q   <= out_pc_d;
        end
    end

    assign push_entry = '{pc: out_pc_q, instr: MemRespData};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_buffer (
        .clk     (CLK),
        .rst_n   (Reset_L),
        .push    (push),
        .pop     (pop),
        .flush   (Redirect),
        .wr_data (push_entry),
        .rd_data (head_entry),
        .count   (buf_count)
    );

    assign MemReq     = mem_req;
    assign MemAddr    = fetch_pc_q;
    assign InstrValid = buf_valid;
    assign Instr      = buf_valid ? head_entry.instr : RESET_INSTR;
    assign InstrPC    = buf_valid ? head_entry.pc : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: hand-computed cycle-by-cycle
// expectations for sequential fetch, back-pressure, redirects and reset.
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        Reset_L;
    logic        MemReq;
    logic [63:0] MemAddr;
    logic        MemGnt;
    logic        MemRespValid;
    logic [31:0] MemRespData;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [63:0] InstrPC;
    logic        InstrReady;
    logic        Redirect;
    logic [63:0] RedirectPC;

    int vectors;
    int miscompares;

    instruction_fetch_unit #(
        .RESET_PC  (64'h0),
        .BUF_DEPTH (2)
    ) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemGnt       (MemGnt),
        .MemRespValid (MemRespValid),
        .MemRespData  (MemRespData),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrReady   (InstrReady),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] data,
                         input logic rdy, input logic redir, input logic [63:0] rpc);
        MemGnt       = gnt;
        MemRespValid = rv;
        MemRespData  = data;
        InstrReady   = rdy;
        Redirect     = redir;
        RedirectPC   = rpc;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset_L     = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);

        // Reset values
        #2;
        check("rst_memreq", MemReq, 0);
        check("rst_memaddr", MemAddr, 64'h0);
        check("rst_ivalid", InstrValid, 0);
        check("rst_instr", Instr, 0);
        check("rst_ipc", InstrPC, 0);
        #10;
        Reset_L = 1'b1;
        #1;
        check("rel_memreq", MemReq, 1);
        check("rel_memaddr", MemAddr, 64'h0);

        // Sequential fetch, response one cycle after grant
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        check("seq_wait_req", MemReq, 0);
        check("seq_wait_addr", MemAddr, 64'h4);
        drive(1'b1, 1'b1, 32'hF84003E9, 1'b1, 1'b0, 64'h0);
        tick();
        check("seq0_valid", InstrValid, 1);
        check("seq0_pc", InstrPC, 64'h0);
        check("seq0_instr", Instr, 32'hF84003E9);
        check("seq0_addr", MemAddr, 64'h4);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        check("seq0_popped", InstrValid, 0);
        drive(1'b1, 1'b1, 32'hF84083EA, 1'b1, 1'b0, 64'h0);
        tick();
        check("seq1_pc", InstrPC, 64'h4);
        check("seq1_instr", Instr, 32'hF84083EA);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b1, 32'hF84103EB, 1'b1, 1'b0, 64'h0);
        tick();
        check("seq2_pc", InstrPC, 64'h8);
        check("seq2_instr", Instr, 32'hF84103EB);
        check("seq2_addr", MemAddr, 64'hC);

        // Back-pressure: InstrReady low, buffer fills to 2 then HOLD
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        tick();
        check("bp_wait_req", MemReq, 0);
        drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 64'h0);
        tick();
        check("bp_hold_req", MemReq, 0);
        check("bp_hold_head", InstrPC, 64'h8);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        tick();
        check("bp_hold2_req", MemReq, 0);
        // Stray response in HOLD must be ignored
        drive(1'b1, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b0, 64'h0);
        tick();
        check("bp_stray_req", MemReq, 0);
        check("bp_stray_head", Instr, 32'hF84103EB);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        tick();
        tick();
        check("bp_hold_end_req", MemReq, 0);
        check("bp_hold_end_pc", InstrPC, 64'h8);
        check("bp_hold_end_addr", MemAddr, 64'h10);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        check("bp_pop1_pc", InstrPC, 64'hC);
        check("bp_pop1_instr", Instr, 32'h00000013);
        check("bp_pop1_req", MemReq, 1);
        tick();
        check("bp_pop2_valid", InstrValid, 0);
        check("bp_stable_req", MemReq, 1);
        check("bp_stable_addr", MemAddr, 64'h10);

        // Redirect to 0x28, then redirect to 0x1C while waiting for 0x28
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h28);
        tick();
        check("rd_addr28", MemAddr, 64'h28);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        check("rd_wait28_req", MemReq, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h1C);
        tick();
        check("rd_drop_req", MemReq, 0);
        check("rd_drop_addr", MemAddr, 64'h1C);
        drive(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 64'h0);
        tick();
        check("rd_dropped_valid", InstrValid, 0);
        check("rd_req1c", MemReq, 1);
        check("rd_addr1c", MemAddr, 64'h1C);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0, 64'h0);
        tick();
        check("rd_pc1c", InstrPC, 64'h1C);
        check("rd_instr1c", Instr, 32'h11111111);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b1, 32'h22222222, 1'b1, 1'b0, 64'h0);
        tick();
        check("rd_pc20", InstrPC, 64'h20);

        // Redirect to 0x37 coincident with grant of 0x24
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h37);
        tick();
        check("rg_flush_valid", InstrValid, 0);
        check("rg_drop_req", MemReq, 0);
        check("rg_addr34", MemAddr, 64'h34);
        drive(1'b1, 1'b1, 32'h33333333, 1'b1, 1'b0, 64'h0);
        tick();
        check("rg_dropped_valid", InstrValid, 0);
        check("rg_req34", MemReq, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b1, 32'h44444444, 1'b1, 1'b0, 64'h0);
        tick();
        check("rg_pc34", InstrPC, 64'h34);
        check("rg_instr34", Instr, 32'h44444444);
        check("rg_addr38", MemAddr, 64'h38);

        // Redirect to the top of the address space; PC wraps to 0
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wr_addr_top", MemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wr_flush_valid", InstrValid, 0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        check("wr_addr_wrap", MemAddr, 64'h0);
        drive(1'b1, 1'b1, 32'h55555555, 1'b1, 1'b0, 64'h0);
        tick();
        check("wr_pc_top", InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wr_req0", MemReq, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b1, 32'h66666666, 1'b1, 1'b0, 64'h0);
        tick();
        check("wr_pc0", InstrPC, 64'h0);
        check("wr_instr0", Instr, 32'h66666666);

        // Reset mid-WAIT, then a stale response after release
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        check("mr_wait_req", MemReq, 0);
        #2;
        Reset_L = 1'b0;
        #1;
        check("mr_rst_req", MemReq, 0);
        check("mr_rst_addr", MemAddr, 64'h0);
        check("mr_rst_valid", InstrValid, 0);
        @(posedge CLK);
        #3;
        Reset_L = 1'b1;
        #1;
        check("mr_rel_req", MemReq, 1);
        check("mr_rel_addr", MemAddr, 64'h0);
        drive(1'b0, 1'b1, 32'h77777777, 1'b1, 1'b0, 64'h0);
        tick();
        check("mr_stale_valid", InstrValid, 0);
        check("mr_stale_req", MemReq, 1);
        check("mr_stale_addr", MemAddr, 64'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b1, 32'h88888888, 1'b1, 1'b0, 64'h0);
        tick();
        check("mr_first_pc", InstrPC, 64'h0);
        check("mr_first_instr", Instr, 32'h88888888);

        // Redirect coincident with a response in WAIT: response discarded
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b0, 1'b1, 32'h99999999, 1'b1, 1'b1, 64'h100);
        tick();
        check("rr_valid", InstrValid, 0);
        check("rr_req", MemReq, 1);
        check("rr_addr", MemAddr, 64'h100);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b1, 1'b1, 32'hAAAAAAAA, 1'b1, 1'b0, 64'h0);
        tick();
        check("rr_pc", InstrPC, 64'h100);
        check("rr_instr", Instr, 32'hAAAAAAAA);

        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
